sreg_file: RTL
==============

# sreg_file

Special-purpose register bank on the receiving end of the special-register write decoder. It holds the eight special registers: Rcol, Rrow, Ri, Rj, Rtotal, Raddress, Rbnd, RcolTemp. It consumes the decoder's one-hot write-enable vector, applies per-register increments, and provides a registered read port back to the datapath bus. It also exposes loop-bound compare flags to the control unit.

## Interface
Parameters:
- WIDTH, 16, data width of every special register and of the bus.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- sreg_wr_ctrl_signals  in  8  one-hot write enables. Bit 7 = Rcol, 6 = Rrow, 5 = Ri, 4 = Rj, 3 = Rtotal, 2 = Raddress, 1 = Rbnd, 0 = RcolTemp.
- wr_data  in  WIDTH  value written to the enabled register.
- inc_ctrl  in  8  per-register +1 enables, same bit order as sreg_wr_ctrl_signals.
- rd_en  in  1  read request.
- rd_sel  in  4  register select. 1 = Rcol, 2 = Rrow, 3 = Ri, 4 = Rj, 5 = Rtotal, 6 = Raddress, 7 = Rbnd, 8 = RcolTemp.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.
- rd_err  out  1  one-cycle pulse, read of an invalid select.
- wr_err  out  1  one-cycle pulse, write vector was not one-hot.
- i_done  out  1  Ri == Rrow.
- j_done  out  1  Rj == Rcol.

## Operation
- Write: when exactly one bit of sreg_wr_ctrl_signals is set, the corresponding register loads wr_data at the clock edge.
- All-zero write vector means no write.
- More than one bit set:
  - No register loads.
  - wr_err = 1 on the following cycle.
  - Increments still apply.
- Increment: each register whose inc_ctrl bit is set takes value + 1 modulo 2^WIDTH. All-ones wraps to 0. Multiple increments may occur in the same cycle.
- Write and increment to the same register in the same cycle: the write wins and the increment is dropped.
- Read: rd_en sampled at the edge.
  - Valid rd_sel: rd_data takes the register value as it stood before that edge, so read-during-write returns the old value.
  - rd_sel = 0 or 9–15: rd_data = 0 and rd_err = 1.
  - rd_valid = 1 in either case.
- rd_en = 0: rd_valid = 0, rd_err = 0, rd_data holds its last value.
- i_done and j_done are combinational from the current register contents.

## Timing
- Write and increment take effect at the edge; a new value is visible on i_done/j_done and to reads in the next cycle.
- Read latency is 1 cycle. Back-to-back reads are allowed every cycle, and each request produces its own rd_valid pulse.
- wr_err and rd_err are asserted the cycle after the offending edge, for 1 cycle.
- Reset values:
  - All 8 registers = 0.
  - rd_data = 0, rd_valid = 0, rd_err = 0, wr_err = 0.
  - i_done = 1 and j_done = 1, since both sides of each compare are 0.
- Reset asserted mid-operation clears everything immediately. Pending read or write requests are discarded, and no rd_valid pulse follows.
- After rstn deasserts, the first edge at which inputs are honoured is the first rising edge with rstn high.

## Structure
- Shared package holds:
  - The 4-bit register index constants (Rcol = 1 … RcolTemp = 8).
  - The one-hot bit positions (Rcol = 7 … RcolTemp = 0).
  - The WIDTH default.
- The write decoder and this block must both import the package so the encodings cannot drift.
- One sub-module, sreg_cell: a single WIDTH-bit register with load/increment inputs and write-over-increment priority, instantiated 8 times.
- Top level adds:
  - the one-hot check (popcount > 1);
  - the read mux plus output registers;
  - the two comparators.

## Test plan
- Reset, then write 0x0005 to Rrow (vector 0x40), then read rd_sel = 2 -> rd_valid pulse 2 cycles after the write edge, rd_data = 0x0005; i_done goes from 1 to 0.
- Write Ri = 0xFFFF, then inc_ctrl bit 5 for 1 cycle -> read Ri = 0x0000; wrap with no error.
- Same cycle: write Rj = 0x0010 and inc_ctrl bit 4 -> Rj = 0x0010, increment dropped.
- Write vector 0xC0 with wr_data = 0x1234 -> Rcol and Rrow unchanged, wr_err pulse 1 cycle; simultaneous inc of Rtotal still applies.
- Read rd_sel = 9 -> rd_data = 0, rd_valid = 1, rd_err = 1. Read Raddress in the same cycle as writing it with 0x00AA -> old value returned, and the next read returns 0x00AA.
- Assert rstn low between a read request edge and its output cycle -> rd_valid stays 0 and all registers read 0 after release.

Source files
------------

// File: rtl/sreg_file_pkg.sv
// Shared encodings for the special-register bank and its write decoder.
package sreg_file_pkg;

  localparam int SREG_WIDTH = 16;
  localparam int NUM_SREGS  = 8;

  // Read-select indices.
  localparam logic [3:0] RIDX_RCOL     = 4'd1;
  localparam logic [3:0] RIDX_RROW     = 4'd2;
  localparam logic [3:0] RIDX_RI       = 4'd3;
  localparam logic [3:0] RIDX_RJ       = 4'd4;
  localparam logic [3:0] RIDX_RTOTAL   = 4'd5;
  localparam logic [3:0] RIDX_RADDRESS = 4'd6;
  localparam logic [3:0] RIDX_RBND     = 4'd7;
  localparam logic [3:0] RIDX_RCOLTEMP = 4'd8;

  // One-hot write / increment bit positions.
  localparam int BIT_RCOL     = 7;
  localparam int BIT_RROW     = 6;
  localparam int BIT_RI       = 5;
  localparam int BIT_RJ       = 4;
  localparam int BIT_RTOTAL   = 3;
  localparam int BIT_RADDRESS = 2;
  localparam int BIT_RBND     = 1;
  localparam int BIT_RCOLTEMP = 0;

  // Index 1..8 maps onto bit 7..0; callers must range-check the index first.
  function automatic logic [2:0] idx_to_bit(input logic [3:0] idx);
    logic [3:0] t;
    t = 4'd8 - idx;
    return t[2:0];
  endfunction

  // True for a legal read-select index.
  function automatic logic idx_valid(input logic [3:0] idx);
    return (idx >= RIDX_RCOL) && (idx <= RIDX_RCOLTEMP);
  endfunction

endpackage

// File: rtl/sreg_cell.sv
// One special register: load beats increment, increment wraps modulo 2^WIDTH.
module sreg_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ld,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register update with write-over-increment priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    q <= '0;
    else if (ld)  q <= d;
    else if (inc) q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/sreg_file.sv
// Special-register bank: one-hot writes, per-register increments,
// registered read port and loop-bound compare flags.
module sreg_file
  import sreg_file_pkg::*;
#(
  parameter int WIDTH = SREG_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [7:0]       sreg_wr_ctrl_signals,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [7:0]       inc_ctrl,
  input  logic             rd_en,
  input  logic [3:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_err,
  output logic             wr_err,
  output logic             i_done,
  output logic             j_done
);

  localparam int RD_STAGES = 1;

  logic [NUM_SREGS-1:0][WIDTH-1:0] regs;
  logic [NUM_SREGS-1:0]            ld_vec;
  logic                            multi_wr;
  logic                            rd_hit;
  logic [2:0]                      rd_bit;
  logic [WIDTH-1:0]                rd_mux;
  logic [RD_STAGES:0]              vld_pipe;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_wr = |(sreg_wr_ctrl_signals & (sreg_wr_ctrl_signals - 8'd1));
  assign ld_vec   = multi_wr ? '0 : sreg_wr_ctrl_signals;

  for (genvar k = 0; k < NUM_SREGS; k++) begin : g_cell
    sreg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk  (clk),
      .rstn (rstn),
      .ld   (ld_vec[k]),
      .inc  (inc_ctrl[k]),
      .d    (wr_data),
      .q    (regs[k])
    );
  end

  // Read mux: illegal selects return zero and flag an error.
  always_comb begin
    rd_hit = idx_valid(rd_sel);
    rd_bit = idx_to_bit(rd_sel);
    rd_mux = rd_hit ? regs[rd_bit] : '0;
  end

  assign vld_pipe[0] = rd_en;

  // Read valid pipeline.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe[RD_STAGES:1] <= '0;
    else       vld_pipe[RD_STAGES:1] <= vld_pipe[RD_STAGES-1:0];
  end

  // Read data holds between requests; error pulses last one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
      rd_err  <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      if (rd_en) rd_data <= rd_mux;
      rd_err <= rd_en & ~rd_hit;
      wr_err <= multi_wr;
    end
  end

  assign rd_valid = vld_pipe[RD_STAGES];
  assign i_done   = (regs[BIT_RI] == regs[BIT_RROW]);
  assign j_done   = (regs[BIT_RJ] == regs[BIT_RCOL]);

endmodule
